// File: rtl/calc_sequencer.sv
// Control sequencer for the BCD keypad calculator: operand entry, ALU launch/wait, display select.
// Optional CALC_CHAIN_EN: an operator key in SHOW_RES chains the result into operand A.
module calc_sequencer #(
  parameter int NDIGITS = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  input  logic                   alu_done,
  input  logic                   alu_err,
  input  logic [4*NDIGITS-1:0]   alu_result,
  output logic [4*NDIGITS-1:0]   operand_a,
  output logic [4*NDIGITS-1:0]   operand_b,
  output logic [1:0]             op_sel,
  output logic                   alu_start,
  output logic [4*NDIGITS-1:0]   display,
  output logic                   busy,
  output logic [2:0]             state
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(NDIGITS);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    WAIT_ALU = 3'd2,
    SHOW_RES = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg, result_reg;
  logic [1:0]      op_reg;
  logic [CW-1:0]   cnt_a_reg, cnt_b_reg;
  logic [TW-1:0]   tmo_reg;
  logic            start_reg;

  logic            is_digit, is_op, is_eq, is_clr, launch, a_room, b_room;
  logic [1:0]      key_op;
  logic [W-1:0]    a_shift, b_shift;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && (key_code >= 4'hA) && (key_code <= 4'hD);
  assign is_eq    = key_valid && (key_code == 4'hE);
  assign is_clr   = key_valid && (key_code == 4'hF);
  // A..D map to 0..3: low two bits minus 2, modulo 4.
  assign key_op   = key_code[1:0] - 2'd2;
  assign a_shift  = {a_reg[W-5:0], key_code};
  assign b_shift  = {b_reg[W-5:0], key_code};
  assign a_room   = (cnt_a_reg < FULL_CNT);
  assign b_room   = (cnt_b_reg < FULL_CNT);
  assign launch   = (state_reg == ENTER_B) && is_eq && (cnt_b_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ENTER_A;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (is_clr) begin
      state_next = ENTER_A;
    end else begin
      case (state_reg)
        ENTER_A:  if (is_op) state_next = ENTER_B;
        ENTER_B:  if (launch) state_next = WAIT_ALU;
        WAIT_ALU: begin
          // A same-cycle alu_done beats the timeout.
          if (alu_done)                  state_next = alu_err ? ERROR : SHOW_RES;
          else if (tmo_reg == TMO_LIMIT) state_next = ERROR;
        end
        SHOW_RES: begin
          if (is_digit) state_next = ENTER_A;
`ifdef CALC_CHAIN_EN
          if (is_op)    state_next = ENTER_B;
`endif
        end
        ERROR:    state_next = ERROR;
        default:  state_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      op_reg     <= 2'b00;
      cnt_a_reg  <= '0;
      cnt_b_reg  <= '0;
      tmo_reg    <= '0;
      start_reg  <= 1'b0;
    end else begin
      start_reg <= launch;
      tmo_reg   <= (state_reg == WAIT_ALU) ? tmo_reg + TW'(1) : '0;
      if (is_clr) begin
        a_reg      <= '0;
        b_reg      <= '0;
        result_reg <= '0;
        op_reg     <= 2'b00;
        cnt_a_reg  <= '0;
        cnt_b_reg  <= '0;
      end else begin
        case (state_reg)
          ENTER_A: begin
            if (is_digit && a_room) begin
              a_reg     <= a_shift;
              cnt_a_reg <= cnt_a_reg + CW'(1);
            end else if (is_op) begin
              op_reg    <= key_op;
              b_reg     <= '0;
              cnt_b_reg <= '0;
            end
          end
          ENTER_B: begin
            if (is_digit && b_room) begin
              b_reg     <= b_shift;
              cnt_b_reg <= cnt_b_reg + CW'(1);
            end else if (is_op && (cnt_b_reg == '0)) begin
              op_reg <= key_op;
            end
          end
          WAIT_ALU: if (alu_done && !alu_err) result_reg <= alu_result;
          SHOW_RES: begin
            if (is_digit) begin
              a_reg     <= W'(key_code);
              cnt_a_reg <= CW'(1);
              b_reg     <= '0;
              cnt_b_reg <= '0;
            end
`ifdef CALC_CHAIN_EN
            if (is_op) begin
              a_reg     <= result_reg;
              cnt_a_reg <= FULL_CNT;
              op_reg    <= key_op;
              b_reg     <= '0;
              cnt_b_reg <= '0;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    display = a_reg;
    case (state_reg)
      ENTER_A:           display = a_reg;
      ENTER_B, WAIT_ALU: display = b_reg;
      SHOW_RES:          display = result_reg;
      ERROR:             display = {NDIGITS{4'hE}};
      default:           display = a_reg;
    endcase
    busy = (state_reg == WAIT_ALU);
  end

  assign operand_a = a_reg;
  assign operand_b = b_reg;
  assign op_sel    = op_reg;
  assign alu_start = start_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: decimal-value reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key/ALU traffic.
module tb_calc_sequencer;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        alu_done = 1'b0;
  logic        alu_err = 1'b0;
  logic [15:0] alu_result = 16'h0;
  logic [15:0] operand_a, operand_b, display;
  logic [1:0]  op_sel;
  logic        alu_start, busy;
  logic [2:0]  state;

  calc_sequencer #(.NDIGITS(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
    .operand_a(operand_a), .operand_b(operand_b), .op_sel(op_sel),
    .alu_start(alu_start), .display(display), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: operands held as decimal integers plus digit counts.
  int          m_state, m_a, m_b, m_cnt_a, m_cnt_b, m_op, m_wait;
  logic [15:0] m_res;
  bit          m_start;

  // ALU responder state
  bit          bfm_auto = 1'b1;
  bit          bfm_random = 1'b0;
  int          bfm_delay = 3;
  bit          bfm_err = 1'b0;
  logic [15:0] bfm_res = 16'h0;
  int          pend = 0;
  int          n_starts = 0;
  bit          force_done = 1'b0;

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(logic [15:0] x);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic model_clear();
    m_a = 0; m_b = 0; m_cnt_a = 0; m_cnt_b = 0; m_op = 0; m_res = 16'h0;
  endtask

  task automatic model_step();
    bit dig, opk, eqk;
    dig = key_valid && (key_code <= 4'd9);
    opk = key_valid && (key_code >= 4'hA) && (key_code <= 4'hD);
    eqk = key_valid && (key_code == 4'hE);
    if (reset) begin
      model_clear();
      m_state = 0; m_wait = 0; m_start = 1'b0;
      return;
    end
    m_start = 1'b0;
    if (key_valid && key_code == 4'hF) begin
      model_clear();
      m_state = 0;
      return;
    end
    case (m_state)
      0: begin
        if (dig && m_cnt_a < 4) begin m_a = m_a * 10 + int'(key_code); m_cnt_a++; end
        else if (opk) begin m_op = int'(key_code) - 10; m_b = 0; m_cnt_b = 0; m_state = 1; end
      end
      1: begin
        if (dig && m_cnt_b < 4) begin m_b = m_b * 10 + int'(key_code); m_cnt_b++; end
        else if (opk && m_cnt_b == 0) m_op = int'(key_code) - 10;
        else if (eqk && m_cnt_b > 0) begin m_state = 2; m_start = 1'b1; m_wait = 0; end
      end
      2: begin
        if (alu_done) begin
          if (alu_err) m_state = 4;
          else begin m_res = alu_result; m_state = 3; end
        end else if (m_wait == TIMEOUT) m_state = 4;
        else m_wait++;
      end
      3: begin
        if (dig) begin
          m_a = int'(key_code); m_cnt_a = 1; m_b = 0; m_cnt_b = 0; m_state = 0;
        end
`ifdef CALC_CHAIN_EN
        else if (opk) begin
          m_a = from_bcd(m_res); m_cnt_a = 4; m_op = int'(key_code) - 10;
          m_b = 0; m_cnt_b = 0; m_state = 1;
        end
`endif
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    chk(name, got, exp);
  endtask

  task automatic compare_all();
    logic [15:0] exp_disp;
    case (m_state)
      0:       exp_disp = to_bcd(m_a);
      1, 2:    exp_disp = to_bcd(m_b);
      3:       exp_disp = m_res;
      default: exp_disp = 16'hEEEE;
    endcase
    vectors++;
    chk("operand_a", operand_a, to_bcd(m_a));
    chk("operand_b", operand_b, to_bcd(m_b));
    chk("op_sel", {14'd0, op_sel}, 16'(m_op));
    chk("alu_start", {15'd0, alu_start}, {15'd0, m_start});
    chk("display", display, exp_disp);
    chk("busy", {15'd0, busy}, {15'd0, (m_state == 2)});
    chk("state", {13'd0, state}, 16'(m_state));
  endtask

  // One clock: model follows the edge, inputs refresh just after it, compare at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    key_valid = 1'b0;
    alu_done = 1'b0;
    alu_err = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin alu_done = 1'b1; alu_err = bfm_err; alu_result = bfm_res; end
    end
    if (force_done) begin
      alu_done = 1'b1; alu_err = 1'b0; alu_result = 16'h1111; force_done = 1'b0;
    end
    if (alu_start) begin
      n_starts++;
      if (bfm_auto) begin
        if (bfm_random) begin
          pend    = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(1, 6));
          bfm_err = ($urandom_range(0, 5) == 0);
          bfm_res = rand_bcd();
        end else begin
          pend = bfm_delay;
        end
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code = c;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    lit("rst_state", {13'd0, state}, 16'd0);
    lit("rst_display", display, 16'h0000);
    lit("rst_start", {15'd0, alu_start}, 16'd0);

    // 12 + 34 with a 3-cycle ALU
    bfm_delay = 3; bfm_err = 1'b0; bfm_res = 16'h0046; n_starts = 0;
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(4'hE);
    idle(6);
    lit("t1_a", operand_a, 16'h0012);
    lit("t1_b", operand_b, 16'h0034);
    lit("t1_op", {14'd0, op_sel}, 16'd0);
    lit("t1_starts", 16'(n_starts), 16'd1);
    lit("t1_display", display, 16'h0046);
    lit("t1_state", {13'd0, state}, 16'd3);

    // fifth digit dropped
    press(4'hF);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    lit("t2_a", operand_a, 16'h1234);

    // ALU error path
    press(4'hF);
    bfm_err = 1'b1;
    press(4'h7); press(4'hD); press(4'h0); press(4'hE);
    idle(6);
    lit("t3_op", {14'd0, op_sel}, 16'd3);
    lit("t3_state", {13'd0, state}, 16'd4);
    lit("t3_display", display, 16'hEEEE);
    press(4'h5);
    lit("t3_ignored", {13'd0, state}, 16'd4);
    press(4'hF);
    lit("t3_clr_state", {13'd0, state}, 16'd0);
    lit("t3_clr_display", display, 16'h0000);
    bfm_err = 1'b0;

    // timeout, then a late alu_done
    bfm_auto = 1'b0; pend = 0;
    press(4'h9); press(4'hB); press(4'h1); press(4'hE);
    for (int i = 0; i < 400 && state != 3'd4; i++) tick();
    lit("t4_timeout", {13'd0, state}, 16'd4);
    force_done = 1'b1;
    idle(2);
    lit("t4_late_done", {13'd0, state}, 16'd4);
    press(4'hF);

    // F beats a same-cycle alu_done in WAIT_ALU
    press(4'h2); press(4'hA); press(4'h3); press(4'hE);
    force_done = 1'b1;
    tick();
    press(4'hF);
    lit("t5_state", {13'd0, state}, 16'd0);
    lit("t5_a", operand_a, 16'h0000);
    lit("t5_b", operand_b, 16'h0000);
    lit("t5_display", display, 16'h0000);

    // reset mid-entry
    press(4'h4); press(4'h5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lit("t6_a", operand_a, 16'h0000);
    lit("t6_state", {13'd0, state}, 16'd0);
    lit("t6_busy", {15'd0, busy}, 16'd0);

    // chained operation
    bfm_auto = 1'b1; bfm_delay = 3; bfm_res = 16'h0008; n_starts = 0;
    press(4'h5); press(4'hA); press(4'h3); press(4'hE);
    idle(6);
    press(4'hA);
`ifdef CALC_CHAIN_EN
    press(4'h2); press(4'hE);
    lit("t7_a", operand_a, 16'h0008);
    lit("t7_b", operand_b, 16'h0002);
    lit("t7_starts", 16'(n_starts), 16'd2);
`else
    lit("t7_state", {13'd0, state}, 16'd3);
    lit("t7_starts", 16'(n_starts), 16'd1);
`endif
    idle(6);
    press(4'hF);

    // randomized traffic
    bfm_random = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      else reset = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        key_valid = 1'b1;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: key_code = 4'($urandom_range(0, 9));
          5, 6:          key_code = 4'($urandom_range(10, 13));
          7, 8:          key_code = 4'hE;
          default:       key_code = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 9));
        endcase
      end
      tick();
    end
    reset = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Top-level control FSM for the TP3 BCD keypad calculator.
- Consumes decoded keypad events and assembles operand A, the operator and operand B as 4-digit packed BCD.
- Launches the shared ALU with a one-cycle start pulse, waits for done or timeout, and selects what the display shows.
- Sits between the keypad decoder and the ALU/display driver; it is the only block that drives alu_start.

Parameters:
- NDIGITS, 4, max BCD digits per operand; operand width is 4*NDIGITS.
- TIMEOUT, 255, cycles allowed in WAIT_ALU before forcing ERROR; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle pulse, key_code valid
- key_code  in  4  0-9 digit; A=+, B=-, C=*, D=/; E='='; F=clear
- alu_done  in  1  one-cycle pulse, ALU result valid
- alu_err  in  1  qualified by alu_done: overflow or divide-by-zero
- alu_result  in  4*NDIGITS  BCD result
- operand_a  out  4*NDIGITS  BCD operand A to ALU
- operand_b  out  4*NDIGITS  BCD operand B to ALU
- op_sel  out  2  00 add, 01 sub, 10 mul, 11 div
- alu_start  out  1  one-cycle start pulse
- display  out  4*NDIGITS  value for 7-seg driver
- busy  out  1  high in WAIT_ALU
- state  out  3  current state, debug

Behaviour:
- Reset (clk edge with reset=1) applies to every register:
  - state=ENTER_A; operand_a=operand_b=0; op_sel=00; alu_start=0; display=0; busy=0; digit counters=0; timeout counter=0.
  - Reset wins over any same-cycle key or alu_done, including mid-WAIT_ALU.
- Keys are acted on in the cycle key_valid=1. Resulting register and output changes are visible the next cycle. One key per pulse.
- State encodings: ENTER_A=0, ENTER_B=1, WAIT_ALU=2, SHOW_RES=3, ERROR=4.
- Digit entry, for the operand currently being entered:
  - If its digit count < NDIGITS: operand <= {operand[4*NDIGITS-5:0], digit}; count+1.
  - If count == NDIGITS: the digit is ignored; no change and no wrap.
- ENTER_A (display=operand_a):
  - Digit: shift into A.
  - Op key: op_sel<=code-A; operand_b<=0; go to ENTER_B. An empty A counts as 0.
  - '=': ignored.
  - F: clear A, B, op_sel and counters; stay in ENTER_A.
- ENTER_B (display=operand_b):
  - Digit: shift into B.
  - Op key: replaces op_sel only while B count==0; otherwise ignored.
  - '=' with B count==0: ignored.
  - '=' with B count>0: next cycle alu_start=1 for exactly 1 cycle; state=WAIT_ALU; timeout counter cleared.
  - F: as in ENTER_A, then go to ENTER_A.
- WAIT_ALU (busy=1; display holds operand_b; operand_a/operand_b/op_sel held stable):
  - alu_done with alu_err=0: display<=alu_result; result latched; go to SHOW_RES.
  - alu_done with alu_err=1: go to ERROR.
  - Timeout counter reaches TIMEOUT with no alu_done: go to ERROR.
  - Digit, op and '=' keys: dropped.
  - F: go to ENTER_A and clear all; an alu_done in the same cycle is discarded.
- Any alu_done outside WAIT_ALU is ignored.
- SHOW_RES (display=latched result):
  - Digit: A<=digit, A count=1, B cleared; go to ENTER_A.
  - F: clear all; go to ENTER_A.
  - '=': ignored.
  - Op key: see Optional Feature.
- ERROR:
  - display = all nibbles 4'hE.
  - Only F leaves (clear all, go to ENTER_A); every other key is ignored.
- Simultaneous key_valid and alu_done in WAIT_ALU: F beats alu_done; any other key is dropped and alu_done is processed.
- alu_start never asserts in two consecutive cycles; there is at most one start per WAIT_ALU entry.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: an op key in SHOW_RES loads operand_a<=result (A count=NDIGITS), sets op_sel, clears B, and goes to ENTER_B. This enables chained operations (5+3=+2=).
- Undefined: an op key in SHOW_RES is ignored.

Test Plan:
- Reset, then keys 1,2,A,3,4,E, with alu_done pulsed 3 cycles after alu_start and alu_result=16'h0046 -> operand_a=16'h0012, operand_b=16'h0034, op_sel=00, a single alu_start pulse, display=16'h0046, state=SHOW_RES.
- Keys 1,2,3,4,5 in ENTER_A -> operand_a=16'h1234; the fifth digit is ignored.
- Keys 7,D,0,E, then alu_done with alu_err=1 -> op_sel=11, state=ERROR, display=16'hEEEE; key 5 is ignored; F -> ENTER_A, display=0.
- Keys 9,B,1,E with no alu_done -> after TIMEOUT(255) cycles state=ERROR; a late alu_done does not change state.
- Keys 2,A,3,E, then F while in WAIT_ALU, with alu_done in the same cycle -> state=ENTER_A, all operands 0, display=0; reset asserted mid-entry also gives all outputs at reset values.
- Chain: 5,A,3,E with result 16'h0008, then A,2,E -> with CALC_CHAIN_EN: operand_a=16'h0008, operand_b=16'h0002, second alu_start pulse; without the macro: the A key is ignored and state stays SHOW_RES.
